// File: rtl/spi_cmd_decoder_if.sv
// spi_cmd_decoder_if
// Bus transaction channel between the SPI command decoder (master) and the
// register/memory fabric that executes its reads and writes (slave).
interface spi_cmd_decoder_if;
  logic        bus_req;
  logic        bus_we;
  logic [16:0] bus_addr;
  logic [7:0]  bus_wr_data;
  logic        bus_ack;
  logic [7:0]  bus_rd_data;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wr_data,
    input  bus_ack,
    input  bus_rd_data
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wr_data,
    output bus_ack,
    output bus_rd_data
  );
endinterface

// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder
// Turns a completed SPI frame (up to four bytes plus a byte count) into one
// bus read or write. Frame end is the rising edge of chip select, brought
// into the sys_clk domain through a two-flop synchroniser. Read data is kept
// in tx_byte so the host can shift it out in its next frame. cmd_err is a
// sticky flag for malformed commands and frames that arrive while busy; it
// clears on the next completed transaction.
//
// Build option: define SPI_CMD_AUTOINC_EN to enable the WRITE_NEXT (010) and
// READ_NEXT (011) opcodes, which address last_addr+1. Without it those
// opcodes are rejected as errors and no address history is kept.
module spi_cmd_decoder (
  input  logic              sys_clk,
  input  logic              reset_n,
  input  logic              spi_cs_n,
  input  logic [7:0]        rx0,
  input  logic [7:0]        rx1,
  input  logic [7:0]        rx2,
  input  logic [7:0]        rx3,
  input  logic [2:0]        rx_count,
  output logic              buf_clear,
  spi_cmd_decoder_if.master bus,
  output logic [7:0]        tx_byte,
  output logic              cmd_err
);

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    REQ    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  // chip-select synchroniser and edge detector
  logic       cs_s1, cs_s2, cs_d;
  logic [1:0] sup_cnt;
  logic       frame_end;

  // frame latched at frame end
  logic [2:0]        op_q;
  logic              a16_q;
  logic [DATA_W-1:0] rx1_q, rx2_q, rx3_q;
  logic [2:0]        cnt_q;

  // decode results
  logic              cmd_ok;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;

  // registered outputs
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wr_data_q;
  logic [DATA_W-1:0] tx_byte_q;
  logic              cmd_err_q;
  logic              buf_clear_q;

  logic ack_take;
  logic overrun;
  logic decode_err;

  // rx0[4:1] carry no meaning in any opcode.
  logic unused_rx0;
  assign unused_rx0 = ^rx0[4:1];

`ifdef SPI_CMD_AUTOINC_EN
  logic [ADDR_W-1:0] last_addr_q;

  // Next sequential address, wrapping modulo 2^17.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return a + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction
`endif

  // Synchronise chip select, remember its previous value and count down the post-reset edge blanking.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      sup_cnt <= 2'd2;
    end else begin
      cs_s1 <= spi_cs_n;
      cs_s2 <= cs_s1;
      cs_d  <= cs_s2;
      if (sup_cnt != 2'd0) begin
        sup_cnt <= sup_cnt - 2'd1;
      end
    end
  end

  // Frame end: synchronised chip select goes high, ignored while blanking after reset.
  assign frame_end = cs_s2 & ~cs_d & (sup_cnt == 2'd0);
  assign overrun   = frame_end & (state_q != IDLE);
  assign ack_take  = (state_q == REQ) & bus.bus_ack;

  // ---- stage: frame capture (IDLE -> DECODE) ----
  // Capture the frame fields when a frame end is accepted; holds otherwise.
  always_ff @(posedge sys_clk) begin
    if ((state_q == IDLE) && frame_end) begin
      op_q  <= rx0[7:5];
      a16_q <= rx0[0];
      rx1_q <= rx1;
      rx2_q <= rx2;
      rx3_q <= rx3;
      cnt_q <= rx_count;
    end
  end

  // Decode the captured frame into a bus command and check its byte count.
  always_comb begin
    cmd_ok   = 1'b0;
    cmd_we   = 1'b0;
    cmd_addr = '0;
    cmd_data = '0;
    case (op_q)
      3'b000: begin
        cmd_we   = 1'b1;
        cmd_addr = {a16_q, rx1_q, rx2_q};
        cmd_data = rx3_q;
        cmd_ok   = (cnt_q == 3'd4);
      end
      3'b001: begin
        cmd_addr = {a16_q, rx1_q, rx2_q};
        cmd_ok   = (cnt_q == 3'd3);
      end
`ifdef SPI_CMD_AUTOINC_EN
      3'b010: begin
        cmd_we   = 1'b1;
        cmd_addr = addr_inc(last_addr_q);
        cmd_data = rx1_q;
        cmd_ok   = (cnt_q == 3'd2);
      end
      3'b011: begin
        cmd_addr = addr_inc(last_addr_q);
        cmd_ok   = (cnt_q == 3'd1);
      end
`endif
      default: cmd_ok = 1'b0;
    endcase
  end

  // An empty frame is discarded quietly; anything else that fails decode is an error.
  assign decode_err = (state_q == DECODE) & (cnt_q != 3'd0) & ~cmd_ok;

  // FSM state register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (frame_end) begin
          state_d = DECODE;
        end
      end
      DECODE: begin
        if ((cnt_q != 3'd0) && cmd_ok) begin
          state_d = REQ;
        end else begin
          state_d = DONE;
        end
      end
      REQ: begin
        if (bus.bus_ack) begin
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- stage: bus request (DECODE -> REQ -> DONE) ----
  // Registered outputs: request/clear follow the next state, command fields load on entry to REQ.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= '0;
      bus_wr_data_q <= '0;
      tx_byte_q     <= '0;
      cmd_err_q     <= 1'b0;
      buf_clear_q   <= 1'b0;
    end else begin
      bus_req_q   <= (state_d == REQ);
      buf_clear_q <= (state_d == DONE);
      if ((state_q == DECODE) && (state_d == REQ)) begin
        bus_we_q      <= cmd_we;
        bus_addr_q    <= cmd_addr;
        bus_wr_data_q <= cmd_data;
      end
      if (ack_take && !bus_we_q) begin
        tx_byte_q <= bus.bus_rd_data;
      end
      // A new error outranks the clear from a coincident ack.
      if (overrun || decode_err) begin
        cmd_err_q <= 1'b1;
      end else if (ack_take) begin
        cmd_err_q <= 1'b0;
      end
    end
  end

`ifdef SPI_CMD_AUTOINC_EN
  // Remember the address of the last completed transaction for the *_NEXT opcodes.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      last_addr_q <= '0;
    end else if (ack_take) begin
      last_addr_q <= bus_addr_q;
    end
  end
`endif

  assign bus.bus_req     = bus_req_q;
  assign bus.bus_we      = bus_we_q;
  assign bus.bus_addr    = bus_addr_q;
  assign bus.bus_wr_data = bus_wr_data_q;
  assign tx_byte         = tx_byte_q;
  assign cmd_err         = cmd_err_q;
  assign buf_clear       = buf_clear_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder
// Self-checking bench for spi_cmd_decoder. Expected transactions come from a
// command-level model (opcode table, byte counts, last address, sticky error).
// Honours SPI_CMD_AUTOINC_EN the same way the design does.
module tb_spi_cmd_decoder;

`ifdef SPI_CMD_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       sys_clk  = 1'b0;
  logic       reset_n  = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic [7:0] rx0 = '0, rx1 = '0, rx2 = '0, rx3 = '0;
  logic [2:0] rx_count = '0;
  logic       buf_clear;
  logic [7:0] tx_byte;
  logic       cmd_err;

  spi_cmd_decoder_if bus_if();

  spi_cmd_decoder dut (
    .sys_clk  (sys_clk),
    .reset_n  (reset_n),
    .spi_cs_n (spi_cs_n),
    .rx0      (rx0),
    .rx1      (rx1),
    .rx2      (rx2),
    .rx3      (rx3),
    .rx_count (rx_count),
    .buf_clear(buf_clear),
    .bus      (bus_if),
    .tx_byte  (tx_byte),
    .cmd_err  (cmd_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // command-level reference state
  int         m_last_addr = 0;
  logic [7:0] m_tx        = '0;
  bit         m_err       = 1'b0;

  // Predict what a frame should do from the opcode table.
  task automatic model_decode(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                              input logic [7:0] b3, input logic [2:0] cnt,
                              output bit valid, output bit err, output bit we,
                              output int addr, output logic [7:0] data);
    int op;
    int need;
    op = int'(b0[7:5]);
    valid = 0; err = 0; we = 0; addr = 0; data = '0;
    if (cnt == 3'd0) return;
    case (op)
      0: need = 4;
      1: need = 3;
      2: need = AUTOINC ? 2 : -1;
      3: need = AUTOINC ? 1 : -1;
      default: need = -1;
    endcase
    if (need != int'(cnt)) begin
      err = 1;
      return;
    end
    valid = 1;
    we    = (op % 2) == 0;
    if (op < 2) addr = int'(b0[0]) * 65536 + int'(b1) * 256 + int'(b2);
    else        addr = (m_last_addr + 1) % 131072;
    if (op == 0)      data = b3;
    else if (op == 2) data = b1;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [2:0] cnt);
    @(negedge sys_clk);
    spi_cs_n = 1'b0;
    rx0 = b0; rx1 = b1; rx2 = b2; rx3 = b3; rx_count = cnt;
    repeat (3) @(negedge sys_clk);
    spi_cs_n = 1'b1;
  endtask

  // One frame end to end: request latency, fields, ack after ack_dly cycles, completion.
  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [2:0] cnt, input int ack_dly,
                           input logic [7:0] rd, input string nm);
    bit ev, ee, ew;
    int ea;
    logic [7:0] ed;
    bit seen;
    int lat, clr, clr_at;
    model_decode(b0, b1, b2, b3, cnt, ev, ee, ew, ea, ed);
    send_frame(b0, b1, b2, b3, cnt);
    seen = 0; lat = 0; clr = 0; clr_at = 0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge sys_clk);
      if (buf_clear) begin clr++; if (clr_at == 0) clr_at = c; end
      if (bus_if.bus_req) begin seen = 1; lat = c; end
    end
    if (ev) begin
      n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL %s.req_seen got %0d want 1", nm, seen); end
      if (seen) begin
        n_cmp++; if (lat != 4) begin n_bad++; $display("FAIL %s.latency got %0d want 4", nm, lat); end
        n_cmp++; if (bus_if.bus_we !== ew) begin n_bad++; $display("FAIL %s.we got %b want %b", nm, bus_if.bus_we, ew); end
        n_cmp++; if (bus_if.bus_addr !== 17'(ea)) begin n_bad++; $display("FAIL %s.addr got %h want %h", nm, bus_if.bus_addr, 17'(ea)); end
        if (ew) begin
          n_cmp++; if (bus_if.bus_wr_data !== ed) begin n_bad++; $display("FAIL %s.wr_data got %h want %h", nm, bus_if.bus_wr_data, ed); end
        end
        for (int k = 0; k < ack_dly; k++) begin
          @(negedge sys_clk);
          n_cmp++;
          if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 17'(ea) || bus_if.bus_we !== ew) begin
            n_bad++; $display("FAIL %s.hold req=%b addr=%h we=%b want 1 %h %b", nm, bus_if.bus_req, bus_if.bus_addr, bus_if.bus_we, 17'(ea), ew);
          end
        end
        bus_if.bus_ack = 1'b1;
        bus_if.bus_rd_data = rd;
        @(negedge sys_clk);
        bus_if.bus_ack = 1'b0;
        if (!ew) m_tx = rd;
        m_last_addr = ea;
        m_err = 1'b0;
        n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL %s.req_drop got %b want 0", nm, bus_if.bus_req); end
        n_cmp++; if (buf_clear !== 1'b1) begin n_bad++; $display("FAIL %s.buf_clear got %b want 1", nm, buf_clear); end
        n_cmp++; if (tx_byte !== m_tx) begin n_bad++; $display("FAIL %s.tx_byte got %h want %h", nm, tx_byte, m_tx); end
        n_cmp++; if (cmd_err !== m_err) begin n_bad++; $display("FAIL %s.cmd_err got %b want %b", nm, cmd_err, m_err); end
        @(negedge sys_clk);
        n_cmp++; if (buf_clear !== 1'b0) begin n_bad++; $display("FAIL %s.buf_clear_end got %b want 0", nm, buf_clear); end
      end
    end else begin
      if (ee) m_err = 1'b1;
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL %s.no_req got %b want 0", nm, seen); end
      n_cmp++; if (clr != 1 || clr_at != 4) begin n_bad++; $display("FAIL %s.clear_pulse got %0d@%0d want 1@4", nm, clr, clr_at); end
      n_cmp++; if (cmd_err !== m_err) begin n_bad++; $display("FAIL %s.cmd_err got %b want %b", nm, cmd_err, m_err); end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #12;
    n_cmp++;
    if ({bus_if.bus_req, bus_if.bus_we, buf_clear, cmd_err} !== 4'b0 || bus_if.bus_addr !== 17'h0 ||
        bus_if.bus_wr_data !== 8'h0 || tx_byte !== 8'h0) begin
      n_bad++; $display("FAIL reset.outputs req=%b we=%b clr=%b err=%b addr=%h wd=%h tx=%h want all 0",
                        bus_if.bus_req, bus_if.bus_we, buf_clear, cmd_err, bus_if.bus_addr, bus_if.bus_wr_data, tx_byte);
    end
    @(negedge sys_clk);
    reset_n = 1'b1;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic test_write_at;
    run_frame(8'h01, 8'h80, 8'h00, 8'h5A, 3'd4, 2, 8'h00, "write_at");
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL write_at.err_const got %b want 0", cmd_err); end
  endtask

  task automatic test_autoinc;
    run_frame(8'h20, 8'hFF, 8'hFF, 8'h00, 3'd3, 1, 8'hC3, "read_at");
    n_cmp++; if (tx_byte !== 8'hC3) begin n_bad++; $display("FAIL read_at.tx_const got %h want c3", tx_byte); end
    if (AUTOINC) begin
      run_frame(8'h60, 8'h00, 8'h00, 8'h00, 3'd1, 0, 8'h11, "read_next");
      run_frame(8'h21, 8'hFF, 8'hFF, 8'h00, 3'd3, 0, 8'h22, "read_at_top");
      run_frame(8'h60, 8'h00, 8'h00, 8'h00, 3'd1, 3, 8'h33, "read_next_wrap");
      run_frame(8'h40, 8'h77, 8'h00, 8'h00, 3'd2, 1, 8'h00, "write_next");
    end else begin
      run_frame(8'h40, 8'h77, 8'h00, 8'h00, 3'd2, 0, 8'h00, "write_next_off");
      n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL write_next_off.err_const got %b want 1", cmd_err); end
    end
  endtask

  task automatic test_errors;
    run_frame(8'hE0, 8'h12, 8'h34, 8'h56, 3'd4, 0, 8'h00, "bad_opcode");
    n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL bad_opcode.err_const got %b want 1", cmd_err); end
    run_frame(8'h00, 8'h12, 8'h34, 8'h56, 3'd3, 0, 8'h00, "bad_count");
    run_frame(8'h00, 8'h12, 8'h34, 8'h56, 3'd0, 0, 8'h00, "empty_frame");
    n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL empty_frame.err_kept got %b want 1", cmd_err); end
    run_frame(8'h00, 8'h01, 8'h02, 8'hA5, 3'd4, 0, 8'h00, "clear_err");
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL clear_err.err_const got %b want 0", cmd_err); end
  endtask

  task automatic test_random;
    logic [7:0] b0, b1, b2, b3;
    logic [2:0] cnt;
    int op;
    for (int i = 0; i < 30; i++) begin
      op = $urandom_range(0, 7);
      b0 = {3'(op), 5'($urandom_range(0, 31))};
      b1 = 8'($urandom); b2 = 8'($urandom); b3 = 8'($urandom);
      if (op < 4 && $urandom_range(0, 3) != 0) cnt = 3'(4 - op);
      else cnt = 3'($urandom_range(0, 4));
      run_frame(b0, b1, b2, b3, cnt, $urandom_range(0, 3), 8'($urandom), "random");
    end
  endtask

  task automatic test_overrun;
    bit seen;
    int hold_bad;
    int extra;
    send_frame(8'h00, 8'h34, 8'h56, 8'h9C, 3'd4);
    seen = 0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge sys_clk);
      if (bus_if.bus_req) seen = 1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL overrun.req_seen got %b want 1", seen); end
    // second frame arrives while the first is still waiting for its ack
    send_frame(8'h20, 8'hAB, 8'hCD, 8'hEF, 3'd3);
    hold_bad = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge sys_clk);
      if (bus_if.bus_req !== 1'b1 || bus_if.bus_addr !== 17'h03456 || bus_if.bus_we !== 1'b1 ||
          bus_if.bus_wr_data !== 8'h9C) hold_bad++;
    end
    n_cmp++; if (hold_bad != 0) begin n_bad++; $display("FAIL overrun.hold got %0d bad cycles want 0", hold_bad); end
    n_cmp++; if (cmd_err !== 1'b1) begin n_bad++; $display("FAIL overrun.err got %b want 1", cmd_err); end
    bus_if.bus_ack = 1'b1;
    @(negedge sys_clk);
    bus_if.bus_ack = 1'b0;
    m_last_addr = 32'h03456;
    m_err = 1'b0;
    n_cmp++; if (bus_if.bus_req !== 1'b0 || buf_clear !== 1'b1) begin n_bad++; $display("FAIL overrun.complete req=%b clr=%b want 0 1", bus_if.bus_req, buf_clear); end
    n_cmp++; if (cmd_err !== 1'b0) begin n_bad++; $display("FAIL overrun.err_clear got %b want 0", cmd_err); end
    extra = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge sys_clk);
      if (bus_if.bus_req) extra++;
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL overrun.dropped got %0d req cycles want 0", extra); end
  endtask

  task automatic test_reset_mid_req;
    bit seen;
    int act;
    send_frame(8'h01, 8'h11, 8'h22, 8'h33, 3'd4);
    seen = 0;
    for (int c = 1; c <= 10 && !seen; c++) begin
      @(negedge sys_clk);
      if (bus_if.bus_req) seen = 1;
    end
    n_cmp++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rst_mid.req_seen got %b want 1", seen); end
    #2 reset_n = 1'b0;
    #1;
    m_last_addr = 0; m_tx = '0; m_err = 1'b0;
    n_cmp++; if (bus_if.bus_req !== 1'b0) begin n_bad++; $display("FAIL rst_mid.req_async got %b want 0", bus_if.bus_req); end
    n_cmp++;
    if ({bus_if.bus_we, buf_clear, cmd_err} !== 3'b0 || bus_if.bus_addr !== 17'h0 ||
        bus_if.bus_wr_data !== 8'h0 || tx_byte !== 8'h0) begin
      n_bad++; $display("FAIL rst_mid.outputs we=%b clr=%b err=%b addr=%h wd=%h tx=%h want all 0",
                        bus_if.bus_we, buf_clear, cmd_err, bus_if.bus_addr, bus_if.bus_wr_data, tx_byte);
    end
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    act = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge sys_clk);
      if (bus_if.bus_req || buf_clear) act++;
    end
    n_cmp++; if (act != 0) begin n_bad++; $display("FAIL rst_mid.release_quiet got %0d active cycles want 0", act); end
    n_cmp++; if (cmd_err !== 1'b0 || tx_byte !== 8'h0) begin n_bad++; $display("FAIL rst_mid.quiet_state err=%b tx=%h want 0 00", cmd_err, tx_byte); end
    run_frame(8'h20, 8'h00, 8'h10, 8'h00, 3'd3, 1, 8'h5C, "after_reset");
  endtask

  initial begin
    bus_if.bus_ack = 1'b0;
    bus_if.bus_rd_data = '0;
    test_reset();
    test_write_at();
    test_autoinc();
    test_errors();
    test_random();
    test_overrun();
    test_reset_mid_req();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog.timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spi_cmd_decoder.md
SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 SHALL have port sys_clk  input  1  system clock; all state on its rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port spi_cs_n  input  1  raw SPI chip select, asynchronous to sys_clk.
REQ-004 SHALL have ports rx0, rx1, rx2, rx3  input  8 each  received frame bytes; stable while spi_cs_n high.
REQ-005 SHALL have port rx_count  input  3  bytes received in the frame; stable while spi_cs_n high.
REQ-006 SHALL have port buf_clear  output  1  one-cycle pulse requesting the upstream byte buffer clear its count.
REQ-007 SHALL have port bus_req  output  1  bus transaction request.
REQ-008 SHALL have port bus_we  output  1  1 = write, 0 = read.
REQ-009 SHALL have port bus_addr  output  17  transaction address.
REQ-010 SHALL have port bus_wr_data  output  8  write data.
REQ-011 SHALL have port bus_ack  input  1  transaction completed this cycle.
REQ-012 SHALL have port bus_rd_data  input  8  read data, valid when bus_ack is high.
REQ-013 SHALL have port tx_byte  output  8  last read data, shifted out in the next SPI frame.
REQ-014 SHALL have port cmd_err  output  1  sticky error flag.

Function
REQ-015 SHALL synchronise spi_cs_n through two flops and detect a rising edge (frame end) on the synchronised signal.
REQ-016 SHALL use the states IDLE, DECODE, REQ and DONE; a frame-end edge in IDLE SHALL move to DECODE and latch rx0..rx3 and rx_count.
REQ-017 SHALL decode the opcode from rx0[7:5]:
- 000 WRITE_AT, rx_count==4: addr = {rx0[0], rx1, rx2}, data = rx3.
- 001 READ_AT, rx_count==3: addr = {rx0[0], rx1, rx2}.
- 010 WRITE_NEXT, rx_count==2: addr = last_addr+1, data = rx1.
- 011 READ_NEXT, rx_count==1: addr = last_addr+1.
REQ-018 SHALL treat any other opcode, or an rx_count mismatch, as an error: set cmd_err, issue no bus transaction, and go DECODE->DONE.
REQ-019 For a valid command, SHALL go DECODE->REQ, driving bus_req=1 with bus_we, bus_addr and bus_wr_data registered and held constant for the whole of REQ.
REQ-020 bus_req SHALL first be high 2 sys_clk cycles after the cycle in which the frame-end edge is detected.
REQ-021 SHALL stay in REQ until bus_ack is sampled high, including an ack in the first REQ cycle; bus_req SHALL drop in the cycle after the ack.
REQ-022 On the ack of a read, SHALL load tx_byte from bus_rd_data; writes SHALL leave tx_byte unchanged.
REQ-023 On any ack, SHALL set last_addr = bus_addr and clear cmd_err.
REQ-024 last_addr+1 SHALL wrap from 0x1FFFF to 0x00000 (17-bit modulo).
REQ-025 DONE SHALL pulse buf_clear for exactly one cycle, then return to IDLE.
REQ-026 A frame-end edge seen outside IDLE SHALL drop that frame and set cmd_err (overrun), leaving the current transaction intact.
REQ-027 A frame with rx_count==0 SHALL be ignored silently: go to DONE and pulse buf_clear, with no error.
REQ-028 spi_cs_n falling edges SHALL have no effect on state.

Reset
REQ-029 Asserting reset_n low SHALL asynchronously force: state IDLE; bus_req, bus_we, buf_clear and cmd_err 0; bus_addr, bus_wr_data, tx_byte and last_addr 0; both sync flops 1.
REQ-030 Reset during REQ SHALL drop bus_req immediately, with no completion side effects.
REQ-031 The first edge-detect SHALL be suppressed for 2 cycles after reset release, so a high spi_cs_n at release is not taken as a frame end.

Configuration
REQ-032 Macro SPI_CMD_AUTOINC_EN defined: WRITE_NEXT and READ_NEXT SHALL be decoded as in REQ-017.
REQ-033 Macro SPI_CMD_AUTOINC_EN undefined: opcodes 010 and 011 SHALL be errors per REQ-018, and last_addr logic MAY be omitted.

Verification
REQ-034 WRITE_AT: rx={0x01,0x80,0x00,0x5A}, count 4, frame end -> bus_req 2 cycles later, we=1, addr=0x18000, data=0x5A; ack -> buf_clear pulse, cmd_err=0.
REQ-035 READ_AT then READ_NEXT: READ_AT 0x0FFFF, ack with rd_data=0xC3 -> tx_byte=0xC3; READ_NEXT -> addr 0x10000. Also READ_NEXT with last_addr=0x1FFFF -> addr 0x00000.
REQ-036 Errors: opcode 111, or WRITE_AT with count 3 -> no bus_req, cmd_err=1, buf_clear pulse; next valid command ack -> cmd_err=0.
REQ-037 Overrun and ack delay: hold bus_ack low 10 cycles, send a second frame end during REQ -> first transaction completes unchanged, second frame dropped, cmd_err=1.
REQ-038 Reset mid-REQ: assert reset_n low while bus_req=1 -> bus_req=0 asynchronously, all outputs at reset values; spi_cs_n high at release -> no transaction.
REQ-039 Macro undefined: WRITE_NEXT frame -> cmd_err=1, no bus_req.
